// File: rtl/lane_pack_pkg.sv
// Shared constants and types for the lane packer: one beat is a lane vector,
// BEATS beats form one output word.
package lane_pack_pkg;

  localparam int unsigned LANES   = 8;
  localparam int unsigned LANE_W  = 4;
  localparam int unsigned BEATS   = 4;
  localparam int unsigned VEC_W   = LANES * LANE_W;
  localparam int unsigned WORD_W  = BEATS * VEC_W;
  localparam int unsigned BEATS_W = $clog2(BEATS + 1);

  typedef logic [VEC_W-1:0]   lane_vec_t;
  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [BEATS_W-1:0] beats_t;

endpackage

// File: rtl/lane_pack_buf.sv
// Output FIFO of {word, beat count} entries: circular buffer with wrapping
// read/write pointers and an occupancy count.
module lane_pack_buf #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned BEATS_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [DATA_W-1:0]  push_data,
  input  logic [BEATS_W-1:0] push_beats,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic [DATA_W-1:0]  head_data,
  output logic [BEATS_W-1:0] head_beats
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);

  logic [DATA_W-1:0]  data_mem  [DEPTH];
  logic [BEATS_W-1:0] beats_mem [DEPTH];
  logic [PW-1:0]      wr_q, rd_q;
  logic [OW-1:0]      occ_q;
  logic               do_push, do_pop;

  assign full    = (occ_q == OW'(DEPTH));
  assign empty   = (occ_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_data  = data_mem[rd_q];
  assign head_beats = beats_mem[rd_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      if (do_push) wr_q <= (wr_q == LastPtr) ? '0 : wr_q + 1'b1;
      if (do_pop)  rd_q <= (rd_q == LastPtr) ? '0 : rd_q + 1'b1;
      if (do_push && !do_pop)      occ_q <= occ_q + 1'b1;
      else if (do_pop && !do_push) occ_q <= occ_q - 1'b1;
    end
  end

  // Storage needs no reset: the top gates the head with empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      data_mem[wr_q]  <= push_data;
      beats_mem[wr_q] <= push_beats;
    end
  end

endmodule

// File: rtl/lane_pack_fifo.sv
// Packs BEATS lane-vector beats into one wide word; full words and flushed
// partial words are queued in a small output FIFO.
module lane_pack_fifo #(
  parameter int unsigned LANES  = lane_pack_pkg::LANES,
  parameter int unsigned LANE_W = lane_pack_pkg::LANE_W,
  parameter int unsigned BEATS  = lane_pack_pkg::BEATS,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LANES*LANE_W-1:0]         in_data,
  input  logic                            flush,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [BEATS*LANES*LANE_W-1:0]   out_data,
  output logic [$clog2(BEATS+1)-1:0]      out_beats
);

  import lane_pack_pkg::*;

  localparam int unsigned VW = LANES * LANE_W;
  localparam int unsigned WW = BEATS * VW;
  localparam int unsigned BW = $clog2(BEATS + 1);
  localparam int unsigned CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LastBeat = CW'(BEATS - 1);

  logic [WW-1:0] acc_q, acc_d, acc_wr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flush_q, flush_d;
  logic          fire, push, pop, full, empty;
  logic [WW-1:0] push_data, head_data;
  logic [BW-1:0] push_beats, head_beats;

  // Registered state only, so no combinational path from out_ready.
  assign in_ready  = !flush_q && ((cnt_q != LastBeat) || !full);
  assign fire      = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = empty ? '0 : head_data;
  assign out_beats = empty ? '0 : head_beats;

  always_comb begin
    acc_wr = acc_q;
    acc_wr[cnt_q*VW +: VW] = in_data;
  end

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    flush_d    = flush_q || flush;
    push       = 1'b0;
    push_data  = acc_wr;
    push_beats = BW'(BEATS);
    if (fire) begin
      if (cnt_q == LastBeat) begin
        push  = 1'b1;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = acc_wr;
        cnt_d = cnt_q + 1'b1;
      end
    end else if (flush_q && !full) begin
      // Unwritten slices of acc are already zero; an empty flush pushes nothing.
      push       = (cnt_q != '0);
      push_data  = acc_q;
      push_beats = BW'(cnt_q);
      acc_d      = '0;
      cnt_d      = '0;
      flush_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  lane_pack_buf #(
    .DEPTH   (DEPTH),
    .DATA_W  (WW),
    .BEATS_W (BW)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_data),
    .push_beats (push_beats),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .head_data  (head_data),
    .head_beats (head_beats)
  );

endmodule

// File: tb/tb_lane_pack_fifo.sv
// Scoreboard bench for lane_pack_fifo: a queue-based reference model predicts
// in_ready, out_valid and every emitted word; a monitor checks words on pop.
module tb_lane_pack_fifo;
  import lane_pack_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic      clk = 1'b0;
  logic      reset = 1'b1;
  logic      in_valid = 1'b0;
  logic      flush = 1'b0;
  logic      out_ready = 1'b0;
  lane_vec_t in_data = '0;
  logic      in_ready, out_valid;
  word_t     out_data;
  beats_t    out_beats;

  int total = 0;
  int bad = 0;
  int mode = 0;    // out_ready: 0 low, 1 high, 2 random
  int nwords = 0;

  // Reference model state
  lane_vec_t part[$];
  word_t     sb_data[$];
  beats_t    sb_beats[$];
  int        occ = 0;
  bit        fp = 1'b0;

  always #5 clk = ~clk;

  lane_pack_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_beats (out_beats)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_push();
    word_t w = '0;
    for (int i = 0; i < part.size(); i++) w[i*VEC_W +: VEC_W] = part[i];
    sb_data.push_back(w);
    sb_beats.push_back(beats_t'(part.size()));
    occ++;
    part.delete();
  endtask

  always @(posedge clk) begin
    #2;
    out_ready = (mode == 2) ? ($urandom_range(0, 1) == 1) : (mode == 1);
  end

  // Model: one step per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      part.delete();
      sb_data.delete();
      sb_beats.delete();
      occ = 0;
      fp  = 1'b0;
    end else begin : step
      bit exp_rdy, mfire, mpop, old_fp;
      exp_rdy = !fp && ((part.size() != BEATS - 1) || (occ < DEPTH));
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, occ > 0);
      mfire  = in_valid && exp_rdy;
      mpop   = (occ > 0) && out_ready;
      old_fp = fp;
      fp     = fp || flush;
      if (mfire) begin
        part.push_back(in_data);
        if (part.size() == BEATS) model_push();
      end else if (old_fp && occ < DEPTH) begin
        if (part.size() > 0) model_push();
        part.delete();
        fp = 1'b0;
      end
      if (mpop) occ--;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_data.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %h want none", out_data);
      end else begin
        chk("out_data", out_data, sb_data.pop_front());
        chk("out_beats", out_beats, sb_beats.pop_front());
        nwords++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input lane_vec_t d, input bit fl);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=%0b want 1", in_ready);
    end
    flush = fl;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  initial begin
    int n0, r, n;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_beats", out_beats, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);

    // Full word, streaming
    mode = 1;
    send(32'h76543210, 0);
    send(32'hFEDCBA98, 0);
    send(32'h01234567, 0);
    send(32'h89ABCDEF, 0);
    chk("word4_valid", out_valid, 1);
    chk("word4_data", out_data, 128'h89ABCDEF_01234567_FEDCBA98_76543210);
    chk("word4_beats", out_beats, 4);
    idle(2);

    // Partial word by flush
    send(32'h11111111, 0);
    send(32'h22222222, 0);
    do_flush();
    idle(1);
    chk("flush2_valid", out_valid, 1);
    chk("flush2_data", out_data, 128'h00000000_00000000_22222222_11111111);
    chk("flush2_beats", out_beats, 2);
    idle(2);

    // Back-pressure: FIFO fills, 12th beat stalls, one-cycle bubble
    mode = 0;
    idle(1);
    for (int i = 0; i < 11; i++) send($urandom, 0);
    in_valid = 1'b1;
    in_data  = $urandom;
    idle(3);
    chk("stall_ready", in_ready, 0);
    mode = 1;
    @(negedge clk);
    chk("bubble_ready", in_ready, 0);
    @(posedge clk);
    #1;
    mode = 0;
    chk("after_bubble_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mode = 1;
    idle(8);

    // Flush together with 3rd beat, then an empty flush
    send(32'hAAAAAAAA, 0);
    send(32'hBBBBBBBB, 0);
    send(32'h33333333, 1);
    idle(5);
    n0 = nwords;
    do_flush();
    idle(4);
    chk("noop_flush_valid", out_valid, 0);
    chk("noop_flush_words", nwords, n0);

    // Asynchronous reset mid-operation
    mode = 0;
    idle(1);
    for (int i = 0; i < 6; i++) send($urandom, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_data", out_data, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    n0 = nwords;
    mode = 1;
    idle(1);
    for (int i = 0; i < 4; i++) send($urandom, 0);
    idle(4);
    chk("fresh_words", nwords - n0, 1);

    // Random traffic
    mode = 2;
    repeat (300) begin
      r = $urandom_range(0, 9);
      if (r < 7) send($urandom, r == 0);
      else if (r == 7) do_flush();
      else idle($urandom_range(1, 3));
    end

    mode = 1;
    n = 0;
    idle(2);
    while ((sb_data.size() > 0 || fp) && n < 50) begin
      idle(1);
      n++;
    end
    chk("drain", sb_data.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
